cv32e40p_tb_ctrl_periph: RTL and testbench

//  Memory-mapped testbench control peripheral inside the tb subsystem.
//  - Sits on the core data bus (OBI-style req/gnt/rvalid).
//  - Turns core stores into character output, pass/fail and exit signals.
//  - Its result outputs are the flags the top-level bench watches to end the run.

---
 rtl/cv32e40p_tb_ctrl_pkg.sv | 21 ++
 rtl/cv32e40p_tb_ctrl_fifo.sv | 58 +++++
 rtl/cv32e40p_tb_ctrl_periph.sv | 198 +++++++++++++++++++
 tb/tb_cv32e40p_tb_ctrl_periph.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_tb_ctrl_pkg.sv
// Shared definitions for the tb control peripheral:
// register offsets, magic status values and exit FSM states.
package cv32e40p_tb_ctrl_pkg;

    localparam logic [31:0] BASE_ADDR_DEF  = 32'h1000_0000;
    localparam logic [31:0] PASS_MAGIC_DEF = 32'd123456789;
    localparam logic [31:0] FAIL_MAGIC_DEF = 32'd1;

    localparam logic [4:0] OFF_STDOUT = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_EXIT   = 5'h08;
    localparam logic [4:0] OFF_CYCLES = 5'h0C;
    localparam logic [4:0] OFF_LEVEL  = 5'h10;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } exit_state_e;

endpackage

// File: rtl/cv32e40p_tb_ctrl_fifo.sv
// Synchronous character FIFO (8-bit entries) with occupancy count.
// DEPTH must be a power of two; pointers wrap naturally.
module cv32e40p_tb_ctrl_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push/pop leaves count as is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_tb_ctrl_periph.sv
// Memory-mapped tb control peripheral: stdout FIFO, pass/fail, exit.
// Optional TB_CTRL_STDOUT_PRINT_EN echoes stdout lines to the console.
module cv32e40p_tb_ctrl_periph
    import cv32e40p_tb_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEF,
    parameter logic [31:0] FAIL_MAGIC = FAIL_MAGIC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        stdout_valid_o,
    input  logic        stdout_ready_i,
    output logic [7:0]  stdout_char_o,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic        hit;
    logic [4:0]  off;
    logic        sel_stdout;
    logic        sel_status;
    logic        sel_exit;
    logic        sel_cycles;
    logic        sel_level;
    logic        gnt;
    logic        wr_en;
    logic        rd_en;
    logic        be_all;
    logic        push;
    logic        pop;
    logic        status_wr;
    logic        exit_wr;
    logic        latch_exit;
    logic [AW:0] level;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] rd_val;
    logic [31:0] cycles;
    exit_state_e state_q;
    exit_state_e state_d;

    assign hit        = data_addr_i[31:5] == BASE_ADDR[31:5];
    assign off        = data_addr_i[4:0];
    assign sel_stdout = hit && (off == OFF_STDOUT);
    assign sel_status = hit && (off == OFF_STATUS);
    assign sel_exit   = hit && (off == OFF_EXIT);
    assign sel_cycles = hit && (off == OFF_CYCLES);
    assign sel_level  = hit && (off == OFF_LEVEL);

    // Full is judged on the registered count, so a same-cycle pop
    // does not open the grant.
    assign gnt = rst_ni && data_req_i
              && !(data_we_i && sel_stdout && fifo_full);

    assign data_gnt_o = gnt;
    assign wr_en      = gnt && data_we_i;
    assign rd_en      = gnt && !data_we_i;
    assign be_all     = data_be_i == 4'hF;
    assign push       = wr_en && sel_stdout && data_be_i[0];
    assign status_wr  = wr_en && sel_status && be_all;
    assign exit_wr    = wr_en && sel_exit && be_all;

    assign stdout_valid_o = !fifo_empty;
    assign pop            = stdout_valid_o && stdout_ready_i;
    assign exit_valid_o   = state_q == DONE;

    cv32e40p_tb_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (push),
        .push_data (data_wdata_i[7:0]),
        .pop       (pop),
        .head      (stdout_char_o),
        .count     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Read data mux for the addressed register
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_status: rd_val = {30'b0, tests_failed_o, tests_passed_o};
            sel_exit:   rd_val = exit_value_o;
            sel_cycles: rd_val = cycles;
            sel_level:  rd_val = 32'(level);
            default:    rd_val = '0;
        endcase
    end

    // Response one cycle after every grant; writes return zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            data_rvalid_o <= gnt;
            data_rdata_o  <= rd_en ? rd_val : '0;
        end
    end

    // Sticky pass/fail flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
        end else if (status_wr) begin
            if (data_wdata_i == PASS_MAGIC) begin
                tests_passed_o <= 1'b1;
            end
            if (data_wdata_i == FAIL_MAGIC) begin
                tests_failed_o <= 1'b1;
            end
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // Exit FSM state and latched exit code
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            exit_value_o <= '0;
        end else begin
            state_q <= state_d;
            if (latch_exit) begin
                exit_value_o <= data_wdata_i;
            end
        end
    end

    // Exit FSM: hold off the exit flag until queued chars are gone
    always_comb begin
        state_d    = state_q;
        latch_exit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (exit_wr) begin
                    latch_exit = 1'b1;
                    state_d    = fifo_empty ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !push) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

`ifdef TB_CTRL_STDOUT_PRINT_EN
    string line_buf;

    // Echo popped chars to the console one line at a time
    always @(posedge clk_i) begin
        if (rst_ni && pop) begin
            if (stdout_char_o == 8'h0A) begin
                $write("%s\n", line_buf);
                line_buf = "";
            end else begin
                line_buf = $sformatf("%s%c", line_buf, stdout_char_o);
            end
        end
        if (rst_ni && exit_valid_o && line_buf.len() != 0) begin
            $write("%s\n", line_buf);
            line_buf = "";
        end
    end
`else
    // Characters leave only through the stdout port.
`endif

endmodule

// File: tb/tb_cv32e40p_tb_ctrl_periph.sv
// Self-checking bench for cv32e40p_tb_ctrl_periph.
// Stdout chars are scoreboarded through expected/observed queues.
module tb_cv32e40p_tb_ctrl_periph;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] PASS = 32'd123456789;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        so_valid;
    logic        so_ready;
    logic [7:0]  so_char;
    logic        passed;
    logic        failed;
    logic        exit_valid;
    logic [31:0] exit_value;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_cmp;
    int n_bad;

    cv32e40p_tb_ctrl_periph dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .data_req_i     (req),
        .data_gnt_o     (gnt),
        .data_rvalid_o  (rvalid),
        .data_addr_i    (addr),
        .data_we_i      (we),
        .data_be_i      (be),
        .data_wdata_i   (wdata),
        .data_rdata_o   (rdata),
        .stdout_valid_o (so_valid),
        .stdout_ready_i (so_ready),
        .stdout_char_o  (so_char),
        .tests_passed_o (passed),
        .tests_failed_o (failed),
        .exit_valid_o   (exit_valid),
        .exit_value_o   (exit_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sink: record every char the DUT hands over
    always @(posedge clk) begin
        if (rst_n && so_valid && so_ready) begin
            got_q.push_back(so_char);
        end
    end

    task automatic bus(input logic [4:0] off, input logic w,
                       input logic [3:0] b, input logic [31:0] wd,
                       output logic [31:0] d, output bit ok);
        int n;
        @(negedge clk);
        req = 1'b1; addr = BASE | 32'(off);
        we = w; be = b; wdata = wd;
        #1;
        n = 0;
        while (!gnt && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!gnt) begin
            req = 1'b0; ok = 1'b0; d = '0;
            return;
        end
        @(posedge clk); #1;
        req = 1'b0;
        ok = rvalid;
        d = rdata;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] wd,
                      output bit ok);
        logic [31:0] d;
        bus(off, 1'b1, 4'hF, wd, d, ok);
    endtask

    task automatic rd(input logic [4:0] off, output logic [31:0] d,
                      output bit ok);
        bus(off, 1'b0, 4'hF, 32'h0, d, ok);
    endtask

    task automatic put(input logic [7:0] c, output bit ok);
        wr(5'h00, {24'h0, c}, ok);
        if (ok) exp_q.push_back(c);
    endtask

    task automatic drain();
        so_ready = 1'b1;
        for (int k = 0; k < 100 && so_valid; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit ok;
        rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0;
        be = 4'h0; wdata = '0; so_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({gnt, rvalid, so_valid, passed, failed, exit_valid} !== 6'b0
            || exit_value !== 32'h0 || rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got flags=%b exit=%h rdata=%h want 0",
                     {gnt, rvalid, so_valid, passed, failed, exit_valid},
                     exit_value, rdata);
        end
        rst_n = 1'b1;
        rd(5'h10, d, ok);
        n_cmp++;
        if (!ok || d !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_level: got %h ok=%0d want 0", d, ok);
        end
    endtask

    task automatic test_stdout();
        logic [31:0] d;
        logic [7:0] e, g;
        bit ok;
        so_ready = 1'b1;
        put(8'h48, ok);
        bus(5'h00, 1'b1, 4'hF, 32'h69, d, ok);
        if (ok) exp_q.push_back(8'h69);
        n_cmp++;
        if (!ok || d !== 32'h0) begin
            n_bad++;
            $display("FAIL write_resp: got rdata=%h ok=%0d want 0/1", d, ok);
        end
        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL stdout_char: got %h want %h", g, e);
            end
        end
        rd(5'h10, d, ok);
        n_cmp++;
        if (!ok || d !== 32'd0) begin
            n_bad++;
            $display("FAIL stdout_level: got %h want 0", d);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] d;
        logic [7:0] e, g;
        bit ok;
        int granted;
        so_ready = 1'b0;
        granted = 0;
        for (int i = 0; i < 16; i++) begin
            put(8'h30 + 8'(i), ok);
            if (ok) granted++;
        end
        n_cmp++;
        if (granted != 16) begin
            n_bad++;
            $display("FAIL full_granted: got %0d want 16", granted);
        end
        rd(5'h10, d, ok);
        n_cmp++;
        if (!ok || d !== 32'd16) begin
            n_bad++;
            $display("FAIL full_level: got %0d want 16", d);
        end
        @(negedge clk);
        req = 1'b1; addr = BASE; we = 1'b1; be = 4'hF; wdata = 32'h40;
        #1;
        n_cmp++;
        if (gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL full_stall: got gnt=%b want 0", gnt);
        end
        repeat (3) @(negedge clk);
        so_ready = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pop_same: got gnt=%b want 0", gnt);
        end
        @(posedge clk); #1;
        so_ready = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL after_pop_gnt: got gnt=%b want 1", gnt);
        end
        exp_q.push_back(8'h40);
        @(posedge clk); #1;
        req = 1'b0;
        rd(5'h10, d, ok);
        n_cmp++;
        if (!ok || d !== 32'd16) begin
            n_bad++;
            $display("FAIL refill_level: got %0d want 16", d);
        end
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL full_char: got %h want %h", g, e);
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL extra_chars: got %0d want 0", got_q.size());
        end
        so_ready = 1'b0;
        bus(5'h00, 1'b1, 4'hE, 32'h55, d, ok);
        rd(5'h10, d, ok);
        n_cmp++;
        if (!ok || d !== 32'd0) begin
            n_bad++;
            $display("FAIL be_drop_level: got %0d want 0", d);
        end
        rd(5'h1C, d, ok);
        n_cmp++;
        if (!ok || d !== 32'd0) begin
            n_bad++;
            $display("FAIL unmapped_read: got %h want 0", d);
        end
    endtask

    task automatic test_status();
        logic [31:0] d;
        bit ok;
        wr(5'h04, PASS, ok);
        n_cmp++;
        if (!ok || passed !== 1'b1 || failed !== 1'b0) begin
            n_bad++;
            $display("FAIL pass_flag: got p=%b f=%b want 1 0", passed, failed);
        end
        rd(5'h04, d, ok);
        n_cmp++;
        if (d !== 32'd1) begin
            n_bad++;
            $display("FAIL status_read: got %h want 1", d);
        end
        wr(5'h04, 32'd7, ok);
        rd(5'h04, d, ok);
        n_cmp++;
        if (d !== 32'd1) begin
            n_bad++;
            $display("FAIL status_ignore: got %h want 1", d);
        end
        bus(5'h04, 1'b1, 4'h7, 32'd1, d, ok);
        n_cmp++;
        if (failed !== 1'b0) begin
            n_bad++;
            $display("FAIL status_be: got f=%b want 0", failed);
        end
        wr(5'h04, 32'd1, ok);
        rd(5'h04, d, ok);
        n_cmp++;
        if (d !== 32'd3) begin
            n_bad++;
            $display("FAIL both_flags: got %h want 3", d);
        end
    endtask

    task automatic test_exit();
        logic [31:0] d;
        logic [7:0] e, g;
        bit ok;
        int k;
        so_ready = 1'b0;
        put(8'h61, ok);
        put(8'h62, ok);
        put(8'h63, ok);
        wr(5'h08, 32'd5, ok);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exit_valid !== 1'b0 || exit_value !== 32'd5) begin
            n_bad++;
            $display("FAIL exit_wait: got v=%b code=%0d want 0 5",
                     exit_valid, exit_value);
        end
        rd(5'h08, d, ok);
        n_cmp++;
        if (d !== 32'd5) begin
            n_bad++;
            $display("FAIL exit_read: got %0d want 5", d);
        end
        @(negedge clk);
        so_ready = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (!so_valid) break;
        end
        n_cmp++;
        if (so_valid || exit_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL exit_early: got v=%b fifo=%b want 0 0",
                     exit_valid, so_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (exit_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL exit_rise: got %b want 1", exit_valid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL exit_char: got %h want %h", g, e);
            end
        end
        wr(5'h08, 32'd9, ok);
        n_cmp++;
        if (exit_valid !== 1'b1 || exit_value !== 32'd5) begin
            n_bad++;
            $display("FAIL exit_sticky: got v=%b code=%0d want 1 5",
                     exit_valid, exit_value);
        end
        so_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic v1, v2, v3;
        @(negedge clk);
        req = 1'b1; addr = BASE | 32'h0C; we = 1'b0; be = 4'hF;
        #1;
        n_cmp++;
        if (gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gnt: got %b want 1", gnt);
        end
        @(posedge clk); #1;
        v1 = rvalid; a = rdata;
        @(posedge clk); #1;
        v2 = rvalid; b = rdata;
        req = 1'b0;
        @(posedge clk); #1;
        v3 = rvalid;
        n_cmp++;
        if ({v1, v2, v3} !== 3'b110) begin
            n_bad++;
            $display("FAIL b2b_rvalid: got %b want 110", {v1, v2, v3});
        end
        n_cmp++;
        if (b !== a + 32'd1) begin
            n_bad++;
            $display("FAIL b2b_cycles: got %0d,%0d want step 1", a, b);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        so_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(8'h70 + 8'(i), ok);
        rd(5'h10, d, ok);
        n_cmp++;
        if (d !== 32'd4) begin
            n_bad++;
            $display("FAIL pre_rst_level: got %0d want 4", d);
        end
        @(negedge clk);
        req = 1'b1; addr = BASE | 32'h10; we = 1'b0; be = 4'hF;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, so_valid, passed, failed, exit_valid} !== 5'b0
            || exit_value !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_rst_out: got %b code=%h want 0",
                     {gnt, so_valid, passed, failed, exit_valid},
                     exit_value);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_rvalid: got %b want 0", rvalid);
        end
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        rd(5'h10, d, ok);
        n_cmp++;
        if (!ok || d !== 32'd0) begin
            n_bad++;
            $display("FAIL post_rst_level: got %0d want 0", d);
        end
    endtask

    task automatic test_exit_empty();
        bit ok;
        wr(5'h08, 32'd42, ok);
        n_cmp++;
        if (!ok || exit_valid !== 1'b1 || exit_value !== 32'd42) begin
            n_bad++;
            $display("FAIL exit_empty: got v=%b code=%0d want 1 42",
                     exit_valid, exit_value);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stdout();
        test_fifo_full();
        test_status();
        test_exit();
        test_back_to_back();
        test_reset_mid();
        test_exit_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
